ps2_key_decoder: RTL

//  Producer end of the key-pulse interface the game blocks consume (spacePressed, onePressed).

---
 rtl/ps2_key_decoder_pkg.sv | 22 ++
 rtl/ps2_frame_rx.sv | 107 ++++++++++
 rtl/ps2_key_decoder.sv | 87 ++++++++
 3 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, receiver state encoding and the frame check
// used by the PS/2 key decoder and its frame receiver.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ONE   = 8'h16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_t;

  // A byte is good when data plus parity has odd weight and the stop bit is high.
  function automatic logic frameOk(input logic [7:0] data, input logic parity, input logic stopBit);
    return (^{data, parity}) & stopBit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, detects falling clock edges,
// shifts in start/data/parity/stop and flags good bytes or framing errors.
// rxValid/rxErr are asserted in the same cycle the stop-bit fall is seen
// (or the timeout fires); the decoder registers them.
module ps2_frame_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iPS2_clk,
  input  logic       iPS2_data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxErr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic          clkPrev;
  logic          fall;
  logic          bitIn;
  rxState_t      state;
  logic [7:0]    shiftReg;
  logic [2:0]    bitCnt;
  logic          parityBit;
  logic [CW-1:0] idleCnt;
  logic          timeoutHit;
  logic          stopFall;
  logic          byteGood;

  // Two-flop synchronisers on both pins plus the previous-clock register for edge detect.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], iPS2_clk};
      dataSync <= {dataSync[0], iPS2_data};
      clkPrev  <= clkSync[1];
    end
  end

  assign fall  = clkPrev & ~clkSync[1];
  assign bitIn = dataSync[1];

  // A fall in the same cycle takes priority, so a frame clocked right at the limit survives.
  assign timeoutHit = (state != RX_IDLE) && !fall && (idleCnt == CW'(TIMEOUT_CYCLES - 1));

  // Bit-level FSM with inactivity timeout; a timeout throws away the partial byte.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state     <= RX_IDLE;
      shiftReg  <= 8'h00;
      bitCnt    <= 3'd0;
      parityBit <= 1'b0;
      idleCnt   <= '0;
    end else if (timeoutHit) begin
      state    <= RX_IDLE;
      shiftReg <= 8'h00;
      bitCnt   <= 3'd0;
      idleCnt  <= '0;
    end else begin
      if (fall || state == RX_IDLE) begin
        idleCnt <= '0;
      end else begin
        idleCnt <= idleCnt + CW'(1);
      end
      if (fall) begin
        case (state)
          RX_IDLE: begin
            if (!bitIn) begin
              state  <= RX_DATA;
              bitCnt <= 3'd0;
            end
          end
          RX_DATA: begin
            shiftReg <= {bitIn, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              state <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            parityBit <= bitIn;
            state     <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  assign stopFall = fall && (state == RX_STOP);
  assign byteGood = frameOk(shiftReg, parityBit, bitIn);
  assign rxByte   = shiftReg;
  assign rxValid  = stopFall & byteGood;
  assign rxErr    = (stopFall & ~byteGood) | timeoutHit;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: turns received bytes into make/break/extended tracking
// and emits one pulse per physical key-down for space and '1'; typematic
// repeats of a held key only refresh oScanCode/oCodeValid.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 10000,
  parameter logic [7:0] SPACE_CODE     = SC_SPACE,
  parameter logic [7:0] ONE_CODE       = SC_ONE
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iPS2_clk,
  input  logic       iPS2_data,
  output logic       spacePressed,
  output logic       onePressed,
  output logic [7:0] oScanCode,
  output logic       oCodeValid,
  output logic       oFrameError
);

  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxErr;
  logic       brkFlag;
  logic       extFlag;
  logic       spaceHeld;
  logic       oneHeld;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) frameRx (
    .clk      (clk),
    .iReset   (iReset),
    .iPS2_clk (iPS2_clk),
    .iPS2_data(iPS2_data),
    .rxByte   (rxByte),
    .rxValid  (rxValid),
    .rxErr    (rxErr)
  );

  // Byte layer: prefix flags, held tracking and registered one-cycle output pulses.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      spacePressed <= 1'b0;
      onePressed   <= 1'b0;
      oScanCode    <= 8'h00;
      oCodeValid   <= 1'b0;
      oFrameError  <= 1'b0;
      brkFlag      <= 1'b0;
      extFlag      <= 1'b0;
      spaceHeld    <= 1'b0;
      oneHeld      <= 1'b0;
    end else begin
      spacePressed <= 1'b0;
      onePressed   <= 1'b0;
      oCodeValid   <= 1'b0;
      oFrameError  <= rxErr;
      if (rxValid) begin
        if (rxByte == SC_BREAK) begin
          brkFlag <= 1'b1;
        end else if (rxByte == SC_EXT) begin
          extFlag <= 1'b1;
        end else if (brkFlag) begin
          // Extended releases never match the plain space/'1' keys.
          if (!extFlag && rxByte == SPACE_CODE) spaceHeld <= 1'b0;
          if (!extFlag && rxByte == ONE_CODE)   oneHeld   <= 1'b0;
          brkFlag <= 1'b0;
          extFlag <= 1'b0;
        end else begin
          oScanCode  <= rxByte;
          oCodeValid <= 1'b1;
          if (!extFlag && rxByte == SPACE_CODE && !spaceHeld) begin
            spacePressed <= 1'b1;
            spaceHeld    <= 1'b1;
          end
          if (!extFlag && rxByte == ONE_CODE && !oneHeld) begin
            onePressed <= 1'b1;
            oneHeld    <= 1'b1;
          end
          extFlag <= 1'b0;
        end
      end
    end
  end

endmodule
